// File: rtl/regfile_mp.sv
// Multi-port register file with two write ports, NR combinational read ports,
// write-to-read bypass and a per-register pending-write scoreboard.
module regfile_mp #(
  parameter int W  = 32,
  parameter int RW = 5,
  parameter int NR = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NR-1:0]    rd_en,
  input  logic [NR*RW-1:0] rd_addr,
  output logic [NR*W-1:0]  rd_data,
  output logic [NR-1:0]    rd_busy,
  output logic             stall,
  input  logic             wr0_en,
  input  logic [RW-1:0]    wr0_addr,
  input  logic [W-1:0]     wr0_data,
  input  logic             wr1_en,
  input  logic [RW-1:0]    wr1_addr,
  input  logic [W-1:0]     wr1_data,
  input  logic             iss_en,
  input  logic [RW-1:0]    iss_addr
);

  localparam int NREG = 1 << RW;

  logic [W-1:0]    regs [NREG];
  logic [NREG-1:0] busy;

  // Later assignments win: wr1 over wr0, and an issue over a write-clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
      busy <= '0;
    end else begin
      if (wr0_en && (wr0_addr != '0)) begin
        regs[wr0_addr] <= wr0_data;
        busy[wr0_addr] <= 1'b0;
      end
      if (wr1_en && (wr1_addr != '0)) begin
        regs[wr1_addr] <= wr1_data;
        busy[wr1_addr] <= 1'b0;
      end
      if (iss_en && (iss_addr != '0)) busy[iss_addr] <= 1'b1;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NR; i++) begin
      logic [RW-1:0] a;
      logic          hit0;
      logic          hit1;
      a    = rd_addr[i*RW +: RW];
      hit0 = wr0_en && (wr0_addr == a);
      hit1 = wr1_en && (wr1_addr == a);
      if (rst && rd_en[i] && (a != '0)) begin
        if (hit1)      rd_data[i*W +: W] = wr1_data;
        else if (hit0) rd_data[i*W +: W] = wr0_data;
        else           rd_data[i*W +: W] = regs[a];
        rd_busy[i] = busy[a] && !hit0 && !hit1;
      end
    end
  end

  assign stall = |rd_busy;

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter W, default 32, data word width in bits.
REQ-002 Parameter RW, default 5, register address width; register count is 2**RW.
REQ-003 Parameter NR, default 2, number of read ports (1..4).
REQ-004 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low.
- rd_en  in  NR  per-port read enable.
- rd_addr  in  NR*RW  packed read addresses; port i uses bits [i*RW +: RW].
- rd_data  out  NR*W  packed read data; port i uses bits [i*W +: W].
- rd_busy  out  NR  per-port flag: the register has a pending producer and no bypass is available.
- stall  out  1  OR of rd_busy over all ports.
- wr0_en, wr0_addr, wr0_data  in  1, RW, W  write port 0.
- wr1_en, wr1_addr, wr1_data  in  1, RW, W  write port 1; has priority over port 0.
- iss_en, iss_addr  in  1, RW  marks iss_addr as having a pending write (scoreboard set).

Function
REQ-005 Register 0 SHALL read as zero, SHALL ignore writes, and SHALL never be marked busy.
REQ-006 On each clk edge with rst high, a port with wrX_en=1 and a nonzero address SHALL update that register.
REQ-007 If both write ports target the same nonzero address in one cycle, wr1_data SHALL be stored.
REQ-008 Reads SHALL be combinational, with zero latency from rd_addr to rd_data.
REQ-009 If rd_en[i]=0, rd_addr is 0, or rst is low, rd_data for port i SHALL be zero.
REQ-010 Bypass: if a write port writes rd_addr[i] in the current cycle, rd_data for port i SHALL return that write data instead of the stored value.
REQ-011 In the bypass case, wr1 SHALL take precedence over wr0.
REQ-012 The scoreboard SHALL hold one busy bit per register, cleared at reset.
REQ-013 The busy bit for iss_addr SHALL be set on the edge when iss_en=1 and iss_addr is nonzero.
REQ-014 The busy bit for a written address SHALL be cleared on the edge when either write port writes it.
REQ-015 If issue and write hit the same address in one cycle, the set SHALL win (busy stays 1).
REQ-016 rd_busy[i] SHALL equal rd_en[i] AND busy[rd_addr[i]] AND no same-cycle write to rd_addr[i].
REQ-017 rd_busy[i] SHALL be 0 for address 0 and while rst is low.
REQ-018 stall SHALL be combinational from current inputs and state.
REQ-019 Reading a busy register without bypass SHALL still return the stored (stale) value; the consumer is responsible for honouring stall.

Reset
REQ-020 While rst=0 at a clk edge, all registers SHALL clear to 0, all busy bits SHALL clear to 0, and writes and issues SHALL be ignored.
REQ-021 While rst=0, rd_data, rd_busy and stall SHALL all be 0.
REQ-022 A reset asserted mid-operation SHALL discard pending scoreboard state; the first cycle after rst rises SHALL behave as an empty, all-zero file.

Verification
REQ-023 Reset, then read r1..r31 on all ports -> rd_data=0, stall=0.
REQ-024 Write r5=0x12345678 via wr0 with rd_addr[0]=5 in the same cycle -> bypass gives 0x12345678 that cycle and the stored value the next cycle.
REQ-025 Drive wr0 r7=0xAAAA0000 and wr1 r7=0x5555FFFF simultaneously -> same-cycle read and later read both return 0x5555FFFF.
REQ-026 Issue r9 -> reading r9 next cycle gives rd_busy=1, stall=1; then wr1 r9=0xCAFEF00D -> that cycle rd_busy=0 with data bypassed, and busy is clear afterwards.
REQ-027 Issue r3 and write r3=0x1 in the same cycle -> next cycle rd_busy=1 for r3 and stored value 0x1.
REQ-028 Write r0=0xFFFFFFFF and issue r0, then pulse rst low for 1 cycle with r4 busy -> r0 reads 0 and is never busy; after reset r4 reads 0 with rd_busy=0.
